// File: rtl/gray_ts_arbiter.sv
// Round-robin arbiter sharing one gray-to-binary timestamp decoder among N_REQ requesters,
// with a registered output stream and per-requester sticky monotonicity error flags.
module gray_ts_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 27,
  parameter int ID_W  = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ_VALID,
  input  logic [N_REQ*WIDTH-1:0] REQ_GRAY,
  output logic [N_REQ-1:0]       REQ_READY,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [WIDTH-1:0]       OUT_BIN,
  output logic [ID_W-1:0]        OUT_ID,
  output logic [N_REQ-1:0]       ERR_FLAGS,
  input  logic                   ERR_CLEAR,
  output logic [15:0]            ACCEPT_CNT
);

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] first_seen;
  logic [N_REQ-1:0] err_next;
  logic             found;
  logic             slot_free;
  logic             accept;
  logic             first_sel;
  logic             err_set;
  logic [WIDTH-1:0] gray_sel;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] last_sel;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] last_bin [N_REQ];

  // Search upward from the requester after the last one granted, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && REQ_VALID[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    gray_sel  = '0;
    last_sel  = '0;
    first_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gray_sel  = REQ_GRAY[i*WIDTH +: WIDTH];
        last_sel  = last_bin[i];
        first_sel = first_seen[i];
      end
    end
  end

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int k = 0; k < WIDTH; k++) begin
      bin[k] = ^(gray_sel >> k);
    end
  end

  assign slot_free = ~OUT_VALID | OUT_READY;
  assign accept    = found & slot_free & ~RST;
  assign REQ_READY = (RST || !slot_free) ? '0 : grant;

  // A negative modular difference means the timestamp went backwards.
  assign diff    = bin - last_sel;
  assign err_set = accept & first_sel & diff[WIDTH-1];

  always_comb begin
    err_next = ERR_CLEAR ? '0 : ERR_FLAGS;
    if (err_set) begin
      err_next = err_next | grant;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID  <= 1'b0;
      OUT_BIN    <= '0;
      OUT_ID     <= '0;
      ERR_FLAGS  <= '0;
      ACCEPT_CNT <= '0;
      first_seen <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      for (int i = 0; i < N_REQ; i++) begin
        last_bin[i] <= '0;
      end
    end else begin
      ERR_FLAGS <= err_next;
      if (accept) begin
        OUT_VALID  <= 1'b1;
        OUT_BIN    <= bin;
        OUT_ID     <= grant_idx;
        last_grant <= grant_idx;
        ACCEPT_CNT <= ACCEPT_CNT + 16'd1;
        for (int i = 0; i < N_REQ; i++) begin
          if (grant[i]) begin
            last_bin[i]   <= bin;
            first_seen[i] <= 1'b1;
          end
        end
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_ts_arbiter.sv
// Self-checking bench for gray_ts_arbiter: scoreboard on the output stream plus
// per-scenario inline checks of grants, error flags and the accept counter.
module tb_gray_ts_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 27;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*WIDTH-1:0] req_gray = '0;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH-1:0]       out_bin;
  logic [ID_W-1:0]        out_id;
  logic [N_REQ-1:0]       err_flags;
  logic                   err_clear = 1'b0;
  logic [15:0]            accept_cnt;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] bin;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               errors = 0;
  int               checks = 0;
  int               exp_cnt = 0;
  logic [WIDTH-1:0] cur_bin [N_REQ];

  always #5 clk = ~clk;

  gray_ts_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_GRAY(req_gray), .REQ_READY(req_ready),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_BIN(out_bin), .OUT_ID(out_id),
    .ERR_FLAGS(err_flags), .ERR_CLEAR(err_clear), .ACCEPT_CNT(accept_cnt)
  );

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gray(input int i, input logic [WIDTH-1:0] b);
    cur_bin[i] = b;
    req_gray[i*WIDTH +: WIDTH] = bin2gray(b);
  endtask

  task automatic expect_word(input int id, input logic [WIDTH-1:0] b);
    exp_t e;
    e.id  = id;
    e.bin = b;
    exp_q.push_back(e);
    exp_cnt++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
  endtask

  // Output stream scoreboard: a word is consumed whenever valid and ready meet.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL stream_word: got id=%0d bin=0x%0h, none expected", out_id, out_bin);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_id !== ID_W'(mon_e.id) || out_bin !== mon_e.bin) begin
          errors++;
          $display("[TB] FAIL stream_word: got id=%0d bin=0x%0h, want id=%0d bin=0x%0h",
                   out_id, out_bin, mon_e.id, mon_e.bin);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) set_gray(i, WIDTH'(i + 1));
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("[TB] FAIL reset_ready: got %b, want 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_bin !== '0 || out_id !== '0) begin
      errors++; $display("[TB] FAIL reset_out: got v=%b bin=0x%0h id=%0d, want 0/0/0", out_valid, out_bin, out_id);
    end
    checks++;
    if (err_flags !== '0 || accept_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_state: got err=%b cnt=%0d, want 0/0", err_flags, accept_cnt);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_id[5] = '{0, 1, 2, 3, 0};
    out_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_gray(i, WIDTH'(32'h100 * i));
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== N_REQ'(1 << exp_id[c])) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got %b, want requester %0d", c, req_ready, exp_id[c]);
      end
      if (c > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("[TB] FAIL rr_no_bubble%0d: got out_valid=%b, want 1", c, out_valid);
        end
      end
      expect_word(exp_id[c], cur_bin[exp_id[c]]);
      tick();
      set_gray(exp_id[c], cur_bin[exp_id[c]] + WIDTH'(1));
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req_gray[0 +: WIDTH] = 27'h0000007;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL single_ready: got %b, want 0001", req_ready);
    end
    expect_word(0, 27'h0000005);
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_bin !== 27'h0000005 || out_id !== 2'd0) begin
      errors++; $display("[TB] FAIL single_out: got v=%b bin=0x%0h id=%0d, want 1/0x5/0", out_valid, out_bin, out_id);
    end
    checks++;
    if (accept_cnt !== 16'(exp_cnt)) begin
      errors++; $display("[TB] FAIL single_cnt: got %0d, want %0d", accept_cnt, exp_cnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_drain: got out_valid=%b, want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    set_gray(3, 27'h400);
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("[TB] FAIL bp_first_grant: got %b, want 1000", req_ready);
    end
    expect_word(3, 27'h400);
    tick();
    set_gray(0, 27'h500);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || out_valid !== 1'b1 || out_id !== 2'd3 || out_bin !== 27'h400) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got ready=%b v=%b id=%0d bin=0x%0h, want 0000/1/3/0x400",
                 c, req_ready, out_valid, out_id, out_bin);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL bp_release_grant: got %b, want 0001", req_ready);
    end
    expect_word(0, 27'h500);
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      errors++; $display("[TB] FAIL bp_next_word: got v=%b id=%0d, want 1/0", out_valid, out_id);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_drain: got out_valid=%b, want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_monotonic();
    apply_reset();
    out_ready = 1'b1;
    req_gray[1*WIDTH +: WIDTH] = 27'h0000005;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("[TB] FAIL mono_grant_a: got %b, want 0010", req_ready);
    end
    expect_word(1, 27'd6);
    tick();
    req_gray[1*WIDTH +: WIDTH] = 27'h0000007;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || err_flags !== '0) begin
      errors++; $display("[TB] FAIL mono_grant_b: got ready=%b err=%b, want 0010/0000", req_ready, err_flags);
    end
    expect_word(1, 27'd5);
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (err_flags !== 4'b0010) begin
      errors++; $display("[TB] FAIL mono_err_set: got %b, want 0010", err_flags);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (err_flags !== '0) begin
      errors++; $display("[TB] FAIL mono_err_clear: got %b, want 0000", err_flags);
    end
    tick();
    set_gray(1, 27'd3);
    req_valid = 4'b0010;
    err_clear = 1'b1;
    expect_word(1, 27'd3);
    tick();
    req_valid = '0;
    err_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (err_flags !== 4'b0010) begin
      errors++; $display("[TB] FAIL mono_set_beats_clear: got %b, want 0010", err_flags);
    end
    tick();
    req_valid = 4'b0010;
    err_clear = 1'b1;
    expect_word(1, 27'd3);
    tick();
    req_valid = '0;
    err_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (err_flags !== '0) begin
      errors++; $display("[TB] FAIL mono_repeat_ok: got %b, want 0000", err_flags);
    end
    tick();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    req_gray[2*WIDTH +: WIDTH] = 27'h4000000;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("[TB] FAIL wrap_grant: got %b, want 0100", req_ready);
    end
    expect_word(2, 27'h7FFFFFF);
    tick();
    req_gray[2*WIDTH +: WIDTH] = 27'h0000000;
    expect_word(2, 27'h0000000);
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (err_flags !== '0) begin
      errors++; $display("[TB] FAIL wrap_no_err: got %b, want 0000", err_flags);
    end
    checks++;
    if (accept_cnt !== 16'(exp_cnt)) begin
      errors++; $display("[TB] FAIL wrap_cnt: got %0d, want %0d", accept_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    set_gray(3, 27'h50);
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("[TB] FAIL rmid_grant: got %b, want 1000", req_ready);
    end
    expect_word(3, 27'h50);
    tick();
    set_gray(3, 27'h40);
    expect_word(3, 27'h40);
    tick();
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (err_flags !== 4'b1000 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rmid_pre: got err=%b v=%b, want 1000/1", err_flags, out_valid);
    end
    rst = 1'b1;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("[TB] FAIL rmid_ready_in_rst: got %b, want 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || err_flags !== '0 || accept_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL rmid_post: got v=%b err=%b cnt=%0d, want 0/0000/0", out_valid, err_flags, accept_cnt);
    end
    tick();
    out_ready = 1'b1;
    set_gray(0, 27'h1);
    set_gray(1, 27'h2);
    set_gray(2, 27'h3);
    set_gray(3, 27'h10);
    req_valid = '1;
    for (int c = 0; c < N_REQ; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== N_REQ'(1 << c)) begin
        errors++; $display("[TB] FAIL rmid_order%0d: got %b, want requester %0d", c, req_ready, c);
      end
      expect_word(c, cur_bin[c]);
      tick();
      req_valid[c] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (err_flags !== '0) begin
      errors++; $display("[TB] FAIL rmid_first_no_check: got %b, want 0000", err_flags);
    end
    tick();
    @(negedge clk);
    checks++;
    if (accept_cnt !== 16'(exp_cnt)) begin
      errors++; $display("[TB] FAIL rmid_cnt: got %0d, want %0d", accept_cnt, exp_cnt);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_monotonic();
    test_wrap();
    test_reset_mid();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_empty: got %0d words pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_ts_arbiter.md
Name: gray_ts_arbiter

Overview:
- Shares one gray-to-binary timestamp decoder among N_REQ requesters, e.g. hit-data token timestamp, TLU trigger timestamp and external timestamp modules.
- Round-robin arbitrates valid/ready requests and decodes the granted gray word.
- Presents the binary result with the requester ID on a single registered output stream.
- Tracks the last decoded value per requester and raises sticky error flags on non-monotonic timestamps.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 27, timestamp width in bits
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N_REQ

Ports:
CLK  input  1  single clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
REQ_VALID  input  N_REQ  per-requester request valid
REQ_GRAY  input  N_REQ*WIDTH  gray-coded timestamps; requester i at bits [i*WIDTH +: WIDTH]
REQ_READY  output  N_REQ  per-requester accept strobe
OUT_VALID  output  1  decoded word valid
OUT_READY  input  1  downstream accept
OUT_BIN  output  WIDTH  decoded binary timestamp
OUT_ID  output  ID_W  index of the requester that produced OUT_BIN
ERR_FLAGS  output  N_REQ  sticky per-requester monotonicity error
ERR_CLEAR  input  1  clears all ERR_FLAGS
ACCEPT_CNT  output  16  total accepted requests, wraps at 0xFFFF

Behaviour:
- Clock and reset:
  - CLK is the only clock.
  - RST is synchronous and active-high. It clears OUT_VALID, OUT_BIN, OUT_ID, ERR_FLAGS, ACCEPT_CNT and all per-requester first-seen bits.
  - RST sets the round-robin pointer so that requester 0 has top priority.
  - REQ_READY is 0 while RST is high.
- Output slot:
  - There is one output register.
  - slot_free = ~OUT_VALID | OUT_READY.
- Arbitration:
  - Each cycle, grant goes to the first asserted REQ_VALID searching upward from last_grant+1, wrapping modulo N_REQ.
  - REQ_READY[i] = grant[i] & slot_free. At most one bit is set.
  - REQ_READY may depend combinationally on REQ_VALID and OUT_READY.
  - An accept occurs when REQ_VALID[i] & REQ_READY[i].
  - last_grant updates only on an accept.
- Decode:
  - bin[WIDTH-1] = gray[WIDTH-1].
  - bin[k] = gray[k] ^ bin[k+1].
  - Decode is combinational in the accept cycle.
- Latency:
  - An accept at edge t drives OUT_VALID=1 from t+1, with OUT_BIN=decoded value and OUT_ID=i.
  - Throughput is 1 word/cycle when OUT_READY is held high.
- Backpressure:
  - While OUT_VALID=1 and OUT_READY=0, OUT_BIN and OUT_ID hold and all REQ_READY=0.
  - Simultaneous drain and accept in the same cycle is allowed; there is no bubble.
  - OUT_VALID falls after a drain with no accept.
- Requester side:
  - Requesters must hold REQ_GRAY stable while REQ_VALID=1 until accepted.
  - An unaccepted requester keeps its position. Starvation is bounded to N_REQ-1 grants.
- Monotonicity check (on accept for requester i):
  - diff = (new_bin - last_bin[i]) mod 2**WIDTH.
  - If first_seen[i]=1 and diff[WIDTH-1]=1, ERR_FLAGS[i] sets at t+1.
  - diff=0 (repeat) is not an error.
  - Wrap from 2**WIDTH-1 to 0 (diff=1) is not an error.
  - last_bin[i] <= new_bin and first_seen[i] <= 1 on every accept, including accepts that set ERR_FLAGS[i].
  - The first accept per requester after reset performs no check.
- Error clear:
  - ERR_CLEAR=1 clears all flags.
  - If a new error occurs in the same cycle as ERR_CLEAR, the set wins.
  - ERR_CLEAR does not touch last_bin or first_seen.
- ACCEPT_CNT increments by 1 per accept.
- Reset mid-operation: a pending OUT word is discarded and nothing is accepted in the RST cycle.

Test Plan:
- Single request: REQ_GRAY[0]=0x0000007 valid at cycle 0, OUT_READY=1 -> REQ_READY[0]=1 at cycle 0; OUT_VALID=1, OUT_BIN=0x0000005, OUT_ID=0 at cycle 1; ACCEPT_CNT=1.
- Round-robin: all 4 REQ_VALID held high, OUT_READY=1 -> grant order 0,1,2,3,0. OUT_ID sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: OUT_READY=0 for 3 cycles after the first word -> OUT_BIN/OUT_ID stable and REQ_READY=0 throughout. On OUT_READY=1 the next word is accepted in the same cycle and appears the cycle after.
- Monotonic check on requester 1:
  - Sequence gray 0x0000005 (bin 6), then 0x0000007 (bin 5) -> ERR_FLAGS[1]=1 one cycle after the second accept.
  - ERR_CLEAR -> ERR_FLAGS=0.
- Wrap: requester 2 sends gray 0x4000000 (bin 0x7FFFFFF), then gray 0x0000000 -> OUT_BIN 0x7FFFFFF then 0x0000000; ERR_FLAGS[2] stays 0.
- Reset mid-stream: RST=1 while OUT_VALID=1 and OUT_READY=0 -> next cycle OUT_VALID=0, ERR_FLAGS=0, ACCEPT_CNT=0. After release, requester 0 is granted first, and a backward value on any requester raises no error on its first accept.
